// File: rtl/smac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smac_pkg
// Description : Shared constants and helpers for the signed multiply-accumulate
//               pipeline (latency, two's-complement magnitude, sign extension).
// Revision    : 1.0 - initial release
// ============================================================================
package smac_pkg;

    // Widest M+N the generic helpers can handle.
    localparam int c_MAX_W = 128;

    // Cycles from en to vld: input register, M accumulate stages, output register.
    function automatic int smac_latency(input int m);
        return m + 2;
    endfunction

    // Low-order mask of w bits within a c_MAX_W-bit word.
    function automatic logic [c_MAX_W-1:0] low_mask(input int w);
        if (w >= c_MAX_W)
            return '1;
        return (c_MAX_W'(1) << w) - c_MAX_W'(1);
    endfunction

    // Magnitude of the w-bit two's-complement value in the low bits of x.
    // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [c_MAX_W-1:0] mag(input logic [c_MAX_W-1:0] x, input int w);
        logic [c_MAX_W-1:0] mask;
        logic [c_MAX_W-1:0] r;
        logic               neg;
        mask = low_mask(w);
        r    = x & mask;
        neg  = |((r >> (w - 1)) & c_MAX_W'(1));
        if (neg)
            r = (~r + c_MAX_W'(1)) & mask;
        return r;
    endfunction

    // Sign-extend the w-bit value in the low bits of x to c_MAX_W bits.
    function automatic logic [c_MAX_W-1:0] sext(input logic [c_MAX_W-1:0] x, input int w);
        logic [c_MAX_W-1:0] mask;
        logic [c_MAX_W-1:0] r;
        mask = low_mask(w);
        r    = x & mask;
        if (|((r >> (w - 1)) & c_MAX_W'(1)))
            r = r | ~mask;
        return r;
    endfunction

endpackage : smac_pkg
`default_nettype wire

// File: rtl/smac_if.sv
`default_nettype none
// ============================================================================
// Module      : smac_if
// Description : Issue/result bundle of the signed multiply-accumulate pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface smac_if #(
    parameter int M = 32,
    parameter int N = 32
);
    logic           en;
    logic [M-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic           vld;
    logic [M+N-1:0] p;

    modport master (output en, output a, output b, output c, input vld, input p);
    modport slave  (input en, input a, input b, input c, output vld, output p);
endinterface : smac_if
`default_nettype wire

// File: rtl/smac_stage.sv
`default_nettype none
// ============================================================================
// Module      : smac_stage
// Description : One registered shift-and-add step of the unsigned magnitude
//               multiplier; carries |a|, |b|, sign and addend alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module smac_stage #(
    parameter int M = 32,
    parameter int N = 32,
    parameter int K = 1
) (
    input  wire logic           clk,
    input  wire logic [M+N-1:0] i_acc,
    input  wire logic [M-1:0]   i_amag,
    input  wire logic [N-1:0]   i_bmag,
    input  wire logic           i_sign,
    input  wire logic [N-1:0]   i_c,
    output logic      [M+N-1:0] o_acc,
    output logic      [M-1:0]   o_amag,
    output logic      [N-1:0]   o_bmag,
    output logic                o_sign,
    output logic      [N-1:0]   o_c
);
    localparam int c_W = M + N;

    logic [c_W-1:0] w_acc_d;
    logic [M-1:0]   w_amag_d;
    logic [c_W-1:0] r_acc_q;
    logic [M-1:0]   r_amag_q;
    logic [N-1:0]   r_bmag_q;
    logic           r_sign_q;
    logic [N-1:0]   r_c_q;

    // i_amag arrives pre-shifted so bit 0 is original bit K-1; add |b| weighted 2^(K-1).
    always_comb begin
        w_acc_d  = i_acc;
        if (i_amag[0])
            w_acc_d = i_acc + (c_W'(i_bmag) << (K - 1));
        w_amag_d = i_amag >> 1;
    end

    // Register the partial product and the sidebands; datapath is not reset.
    always_ff @(posedge clk) begin
        r_acc_q  <= w_acc_d;
        r_amag_q <= w_amag_d;
        r_bmag_q <= i_bmag;
        r_sign_q <= i_sign;
        r_c_q    <= i_c;
    end

    assign o_acc  = r_acc_q;
    assign o_amag = r_amag_q;
    assign o_bmag = r_bmag_q;
    assign o_sign = r_sign_q;
    assign o_c    = r_c_q;

endmodule : smac_stage
`default_nettype wire

// File: rtl/smac.sv
`default_nettype none
// ============================================================================
// Module      : smac
// Description : Fully pipelined signed multiply-accumulate p = a*b + c.
//               Sign/magnitude shift-and-add, one stage per multiplicand bit,
//               latency M+2, one operation per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module smac
    import smac_pkg::*;
#(
    parameter int M = 32,
    parameter int N = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    smac_if.slave     bus
);
    localparam int c_W       = M + N;
    localparam int c_LATENCY = smac_latency(M);

    if (M < 2) begin : g_chk_m
        $error("smac: M must be at least 2");
    end
    if (N < 1) begin : g_chk_n
        $error("smac: N must be at least 1");
    end
    if (c_W > c_MAX_W) begin : g_chk_w
        $error("smac: M+N exceeds the helper width in smac_pkg");
    end

    // ---------------- stage 0: input register ----------------
    logic [M-1:0] w_amag_d;
    logic [N-1:0] w_bmag_d;
    logic         w_sign_d;
    logic [M-1:0] r_amag_q;
    logic [N-1:0] r_bmag_q;
    logic         r_sign_q;
    logic [N-1:0] r_c_q;

    // Split operands into magnitudes and the product sign.
    always_comb begin
        w_amag_d = M'(mag(c_MAX_W'(bus.a), M));
        w_bmag_d = N'(mag(c_MAX_W'(bus.b), N));
        w_sign_d = bus.a[M-1] ^ bus.b[N-1];
    end

    // Capture the operands; validity is tracked separately so no reset here.
    always_ff @(posedge clk) begin
        r_amag_q <= w_amag_d;
        r_bmag_q <= w_bmag_d;
        r_sign_q <= w_sign_d;
        r_c_q    <= bus.c;
    end

    // ---------------- stages 1..M: shift-and-add chain ----------------
    logic [c_W-1:0] w_acc  [0:M];
    logic [M-1:0]   w_amag [0:M];
    logic [N-1:0]   w_bmag [0:M];
    logic           w_sign [0:M];
    logic [N-1:0]   w_c    [0:M];

    assign w_acc[0]  = '0;
    assign w_amag[0] = r_amag_q;
    assign w_bmag[0] = r_bmag_q;
    assign w_sign[0] = r_sign_q;
    assign w_c[0]    = r_c_q;

    for (genvar k = 1; k <= M; k++) begin : g_stage
        smac_stage #(
            .M (M),
            .N (N),
            .K (k)
        ) u_stage (
            .clk    (clk),
            .i_acc  (w_acc[k-1]),
            .i_amag (w_amag[k-1]),
            .i_bmag (w_bmag[k-1]),
            .i_sign (w_sign[k-1]),
            .i_c    (w_c[k-1]),
            .o_acc  (w_acc[k]),
            .o_amag (w_amag[k]),
            .o_bmag (w_bmag[k]),
            .o_sign (w_sign[k]),
            .o_c    (w_c[k])
        );
    end

    // After the last stage every |a| bit has been consumed and |b| is no longer needed.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_amag[M], w_bmag[M]};

    // ---------------- valid tracking ----------------
    logic [c_LATENCY-1:0] w_vld_sr_d;
    logic [c_LATENCY-1:0] r_vld_sr_q;

    // en delayed by exactly the pipeline depth; bit M marks a valid op in stage M.
    always_comb begin
        w_vld_sr_d = {r_vld_sr_q[c_LATENCY-2:0], bus.en};
    end

    // Reset flushes every in-flight op, including one issued alongside rst.
    always_ff @(posedge clk) begin
        if (rst)
            r_vld_sr_q <= '0;
        else
            r_vld_sr_q <= w_vld_sr_d;
    end

    // ---------------- stage M+1: output register ----------------
    logic [c_W-1:0] w_p_d;
    logic [c_W-1:0] r_p_q;

    // Reapply the sign, add the sign-extended addend; hold p when nothing is arriving.
    always_comb begin
        w_p_d = r_p_q;
        if (r_vld_sr_q[c_LATENCY-2])
            w_p_d = (w_sign[M] ? (c_W'(0) - w_acc[M]) : w_acc[M])
                  + c_W'(sext(c_MAX_W'(w_c[M]), N));
    end

    // Result register; cleared by reset so p reads zero right after it.
    always_ff @(posedge clk) begin
        if (rst)
            r_p_q <= '0;
        else
            r_p_q <= w_p_d;
    end

    assign bus.vld = r_vld_sr_q[c_LATENCY-1];
    assign bus.p   = r_p_q;

endmodule : smac
`default_nettype wire
